// File: rtl/mesi_l1_ctrl.sv
// Direct-mapped MESI L1 controller: core request FSM, snooping-bus master and
// combinational snoop responder for the shared bus.

package mesi_types_pkg;
    parameter int XLEN           = 32;
    parameter int CACHELINE_SIZE = 64;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_cmd_e;

    typedef enum logic [1:0] {
        ST_I = 2'd0,
        ST_S = 2'd1,
        ST_E = 2'd2,
        ST_M = 2'd3
    } mesi_e;
endpackage

module mesi_l1_ctrl
    import mesi_types_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int ID        = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [XLEN-1:0]           cpu_addr,
    input  logic [CACHELINE_SIZE-1:0] cpu_wdata,
    output logic                      cpu_ready,
    output logic                      cpu_resp,
    output logic [CACHELINE_SIZE-1:0] cpu_rdata,
    output logic                      bus_req,
    input  logic                      bus_gnt,
    output logic [1:0]                bus_cmd,
    output logic [XLEN-1:0]           bus_addr,
    output logic [CACHELINE_SIZE-1:0] bus_wdata,
    input  logic [CACHELINE_SIZE-1:0] bus_rdata,
    input  logic                      bus_done,
    input  logic                      bus_shared,
    input  logic                      snoop_valid,
    input  logic [1:0]                snoop_cmd,
    input  logic [XLEN-1:0]           snoop_addr,
    output logic                      snoop_shared,
    output logic                      snoop_flush,
    output logic [CACHELINE_SIZE-1:0] snoop_data
);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int TAGW = XLEN - IDX;

    typedef struct packed {
        mesi_e                     st;
        logic [TAGW-1:0]           tag;
        logic [CACHELINE_SIZE-1:0] data;
    } line_t;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_RESP} fsm_e;

    fsm_e  fsm;
    line_t lines [NUM_LINES];
    logic  gnt_seen;

    logic [IDX-1:0]  cidx, sidx;
    logic [TAGW-1:0] ctag, stag;
    line_t           cl, sl;
    logic            cpu_hit, snoop_hit, snoop_on_cpu_line, snoop_kill, victim_lost;
    mesi_e           snoop_next;

    assign cidx = cpu_addr[IDX-1:0];
    assign ctag = cpu_addr[XLEN-1:IDX];
    assign sidx = snoop_addr[IDX-1:0];
    assign stag = snoop_addr[XLEN-1:IDX];
    assign cl   = lines[cidx];
    assign sl   = lines[sidx];

    assign cpu_hit   = (cl.st != ST_I) && (cl.tag == ctag);
    assign snoop_hit = snoop_valid && (sl.st != ST_I) && (sl.tag == stag);

    assign snoop_shared = snoop_hit;
    assign snoop_flush  = snoop_hit && (sl.st == ST_M) &&
                          (snoop_cmd == BUS_RD || snoop_cmd == BUS_RDX);
    assign snoop_data   = snoop_flush ? sl.data : '0;

    always_comb begin
        snoop_next = sl.st;
        case (snoop_cmd)
            BUS_RD:   snoop_next = ST_S;
            BUS_RDX:  snoop_next = ST_I;
            BUS_UPGR: if (sl.st == ST_S) snoop_next = ST_I;
            default:  ;
        endcase
    end

    // Snoop landing on the line the CPU request is working on this cycle.
    assign snoop_on_cpu_line = snoop_hit && (sidx == cidx);
    assign snoop_kill        = snoop_on_cpu_line && (snoop_next == ST_I);
    // A dirty victim that another master downgraded/stole needs no writeback.
    assign victim_lost       = (cl.st != ST_M) ||
                               (snoop_on_cpu_line && snoop_next != ST_M);

    assign cpu_ready = (fsm == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            cpu_resp  <= 1'b0;
            cpu_rdata <= '0;
            bus_req   <= 1'b0;
            bus_cmd   <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            gnt_seen  <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) lines[i].st <= ST_I;
        end else begin
            cpu_resp <= 1'b0;
            case (fsm)
                S_IDLE: if (cpu_req) begin
                    if (cpu_hit && !cpu_we) begin
                        cpu_rdata <= cl.data;
                        cpu_resp  <= 1'b1;
                        fsm       <= S_RESP;
                    end else if (cpu_hit && cl.st != ST_S) begin
                        lines[cidx].data <= cpu_wdata;
                        lines[cidx].st   <= ST_M;
                        cpu_rdata        <= '0;
                        cpu_resp         <= 1'b1;
                        fsm              <= S_RESP;
                    end else if (cpu_hit) begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= BUS_UPGR;
                        bus_addr <= cpu_addr;
                        fsm      <= S_FILL;
                    end else if (cl.st == ST_M) begin
                        bus_req   <= 1'b1;
                        bus_cmd   <= BUS_WB;
                        bus_addr  <= {cl.tag, cidx};
                        bus_wdata <= cl.data;
                        fsm       <= S_WB;
                    end else begin
                        bus_req  <= 1'b1;
                        bus_cmd  <= cpu_we ? BUS_RDX : BUS_RD;
                        bus_addr <= cpu_addr;
                        fsm      <= S_FILL;
                    end
                end
                S_WB: begin
                    if (bus_done || (!gnt_seen && !bus_gnt && victim_lost)) begin
                        if (bus_done) lines[cidx].st <= ST_I;
                        bus_req  <= 1'b0;
                        gnt_seen <= 1'b0;
                        bus_cmd  <= cpu_we ? BUS_RDX : BUS_RD;
                        bus_addr <= cpu_addr;
                        fsm      <= S_FILL;
                    end else if (bus_req && bus_gnt) begin
                        gnt_seen <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (bus_done) begin
                        bus_req         <= 1'b0;
                        gnt_seen        <= 1'b0;
                        cpu_resp        <= 1'b1;
                        fsm             <= S_RESP;
                        lines[cidx].tag <= ctag;
                        if (bus_cmd == BUS_RD) begin
                            lines[cidx].data <= bus_rdata;
                            lines[cidx].st   <= bus_shared ? ST_S : ST_E;
                            cpu_rdata        <= bus_rdata;
                        end else begin
                            lines[cidx].data <= cpu_wdata;
                            lines[cidx].st   <= ST_M;
                            cpu_rdata        <= '0;
                        end
                    end else begin
                        bus_req <= 1'b1;
                        if (bus_req && bus_gnt) gnt_seen <= 1'b1;
                        // Lost our S copy before winning the bus: upgrade is no longer enough.
                        if (bus_cmd == BUS_UPGR && !gnt_seen && !bus_gnt &&
                            (!cpu_hit || snoop_kill))
                            bus_cmd <= BUS_RDX;
                    end
                end
                S_RESP: fsm <= S_IDLE;
                default: fsm <= S_IDLE;
            endcase
            // Placed last so a snoop wins over any CPU-side update of the same line.
            if (snoop_hit) lines[sidx].st <= snoop_next;
        end
    end

    a_no_req_idle: assert property (@(posedge clk) disable iff (rst)
        (fsm == S_IDLE || fsm == S_RESP) |-> !bus_req)
        else $error("L1[%0d]: bus_req high outside a bus state", ID);

    // Direct-mapped: a refill may only replace a clean or already-written-back victim.
    a_one_line_per_idx: assert property (@(posedge clk) disable iff (rst)
        (fsm == S_FILL && bus_done && bus_cmd != BUS_UPGR) |-> (cl.st != ST_M || cl.tag == ctag))
        else $error("L1[%0d]: refill over a dirty line at index %0d", ID, cidx);

    a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
        (bus_req && (bus_gnt || gnt_seen) && !bus_done) |=> $stable(bus_cmd))
        else $error("L1[%0d]: bus_cmd changed while granted", ID);

endmodule

// File: tb/tb_mesi_l1_ctrl.sv
// Directed bench for mesi_l1_ctrl: vector table of CPU ops and snoops, plus
// hand sequences for upgrade-to-RDX, dirty eviction and mid-transaction reset.

module tb_mesi_l1_ctrl;
    localparam int XL = 32;
    localparam int CL = 64;

    logic          clk = 0, rst = 1;
    logic          cpu_req = 0, cpu_we = 0;
    logic [XL-1:0] cpu_addr = '0;
    logic [CL-1:0] cpu_wdata = '0;
    logic          cpu_ready, cpu_resp;
    logic [CL-1:0] cpu_rdata;
    logic          bus_req, bus_gnt = 0, bus_done = 0, bus_shared = 0;
    logic [1:0]    bus_cmd;
    logic [XL-1:0] bus_addr;
    logic [CL-1:0] bus_wdata, bus_rdata = '0;
    logic          snoop_valid = 0;
    logic [1:0]    snoop_cmd = '0;
    logic [XL-1:0] snoop_addr = '0;
    logic          snoop_shared, snoop_flush;
    logic [CL-1:0] snoop_data;

    mesi_l1_ctrl #(.NUM_LINES(4), .ID(0)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_done(bus_done), .bus_shared(bus_shared),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_shared(snoop_shared), .snoop_flush(snoop_flush), .snoop_data(snoop_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [1:0] RD = 2'd0, RDX = 2'd1, UPGR = 2'd2, WB = 2'd3;
    localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] line_st(input int idx);
        return 2'(dut.lines[idx].st);
    endfunction

    // Bus-side results of the last run_cpu call.
    int            ntx, lat, done_c;
    bit            got;
    logic [1:0]    tx_cmd [4];
    logic [XL-1:0] tx_addr [4];
    logic [CL-1:0] tx_wdata [4];
    logic [CL-1:0] rdata;

    // Called at #1 after a posedge with the DUT idle; returns at #1 after a posedge.
    task automatic run_cpu(input bit we, input logic [XL-1:0] addr, input logic [CL-1:0] wd,
                           input logic [CL-1:0] fill, input bit sh);
        ntx = 0; lat = 0; done_c = 0; got = 0; rdata = '0;
        cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus_done) begin
                bus_done = 0; bus_gnt = 0;
            end else if (bus_gnt) begin
                bus_done = 1; bus_rdata = fill; bus_shared = sh; done_c = c;
            end else if (bus_req) begin
                if (ntx < 4) begin
                    tx_cmd[ntx] = bus_cmd; tx_addr[ntx] = bus_addr; tx_wdata[ntx] = bus_wdata;
                end
                ntx++;
                bus_gnt = 1;
            end
            if (cpu_resp) begin
                got = 1; lat = c; rdata = cpu_rdata;
                break;
            end
        end
        cpu_req = 0;
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL cpu_timeout: no cpu_resp for addr %0h within 60 cycles", addr);
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit            snoop;   // 0: CPU op, 1: snoop
        bit            we;
        logic [1:0]    scmd;
        logic [XL-1:0] addr;
        logic [CL-1:0] wdata;
        logic [CL-1:0] fill;
        bit            sh;
        int            exp_ntx;
        logic [1:0]    exp_cmd;
        logic [CL-1:0] exp_data; // cpu_rdata or snoop_data
        bit            exp_shared;
        bit            exp_flush;
        logic [1:0]    exp_st;
    } vec_t;

    function automatic vec_t cpu_v(input bit we, input logic [XL-1:0] a, input logic [CL-1:0] wd,
                                   input logic [CL-1:0] fill, input bit sh, input int ntx_e,
                                   input logic [1:0] cmd_e, input logic [CL-1:0] rd_e,
                                   input logic [1:0] st_e);
        vec_t v;
        v.snoop = 0; v.we = we; v.scmd = 0; v.addr = a; v.wdata = wd; v.fill = fill; v.sh = sh;
        v.exp_ntx = ntx_e; v.exp_cmd = cmd_e; v.exp_data = rd_e;
        v.exp_shared = 0; v.exp_flush = 0; v.exp_st = st_e;
        return v;
    endfunction

    function automatic vec_t snp_v(input logic [1:0] cmd, input logic [XL-1:0] a, input bit sh_e,
                                   input bit fl_e, input logic [CL-1:0] d_e, input logic [1:0] st_e);
        vec_t v;
        v.snoop = 1; v.we = 0; v.scmd = cmd; v.addr = a; v.wdata = '0; v.fill = '0; v.sh = 0;
        v.exp_ntx = 0; v.exp_cmd = 0; v.exp_data = d_e;
        v.exp_shared = sh_e; v.exp_flush = fl_e; v.exp_st = st_e;
        return v;
    endfunction

    vec_t vt [17];

    initial begin
        //            we  addr  wdata     fill       sh ntx cmd   rdata      state
        vt[0]  = cpu_v(0, 5,    0,        64'hAA,    0, 1,  RD,   64'hAA,    E);
        vt[1]  = cpu_v(0, 5,    0,        0,         0, 0,  RD,   64'hAA,    E);
        vt[2]  = cpu_v(1, 5,    64'h55,   0,         0, 0,  RD,   0,         M);
        vt[3]  = snp_v(RD,   5, 1, 1, 64'h55, S);
        vt[4]  = cpu_v(0, 5,    0,        0,         0, 0,  RD,   64'h55,    S);
        vt[5]  = cpu_v(0, 2,    0,        64'h1234,  1, 1,  RD,   64'h1234,  S);
        vt[6]  = cpu_v(1, 6,    64'h6666, 64'hBAD,   0, 1,  RDX,  0,         M);
        vt[7]  = snp_v(RDX,  6, 1, 1, 64'h6666, I);
        vt[8]  = snp_v(RD,   3, 0, 0, 0, I);
        vt[9]  = cpu_v(0, 0,    0,        64'hC0,    0, 1,  RD,   64'hC0,    E);
        vt[10] = snp_v(RD,   0, 1, 0, 0, S);
        vt[11] = snp_v(UPGR, 0, 1, 0, 0, I);
        vt[12] = cpu_v(0, 7,    0,        64'h7070,  1, 1,  RD,   64'h7070,  S);
        vt[13] = cpu_v(1, 7,    64'h99,   64'hBAD,   0, 1,  UPGR, 0,         M);
        vt[14] = snp_v(WB,   7, 1, 0, 0, M);
        vt[15] = cpu_v(0, 7,    0,        0,         0, 0,  RD,   64'h99,    M);
        vt[16] = snp_v(RD,   4, 0, 0, 0, I);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_resp", cpu_resp, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_cmd", bus_cmd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_line%0d_st", i), line_st(i), I);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", cpu_ready, 1);

        for (int k = 0; k < 17; k++) begin
            if (!vt[k].snoop) begin
                chk($sformatf("v%0d_ready", k), cpu_ready, 1);
                run_cpu(vt[k].we, vt[k].addr, vt[k].wdata, vt[k].fill, vt[k].sh);
                chk($sformatf("v%0d_ntx", k), ntx, vt[k].exp_ntx);
                if (vt[k].exp_ntx > 0 && ntx > 0) begin
                    chk($sformatf("v%0d_cmd", k), tx_cmd[0], vt[k].exp_cmd);
                    chk($sformatf("v%0d_addr", k), tx_addr[0], vt[k].addr);
                    chk($sformatf("v%0d_lat_after_done", k), lat - done_c, 1);
                end else begin
                    chk($sformatf("v%0d_hit_lat", k), lat, 1);
                end
                chk($sformatf("v%0d_rdata", k), rdata, vt[k].exp_data);
            end else begin
                snoop_valid = 1; snoop_cmd = vt[k].scmd; snoop_addr = vt[k].addr;
                #1;
                chk($sformatf("v%0d_snoop_shared", k), snoop_shared, vt[k].exp_shared);
                chk($sformatf("v%0d_snoop_flush", k), snoop_flush, vt[k].exp_flush);
                chk($sformatf("v%0d_snoop_data", k), snoop_data, vt[k].exp_data);
                @(posedge clk); #1;
                snoop_valid = 0;
            end
            chk($sformatf("v%0d_state", k), line_st(int'(vt[k].addr[1:0])), vt[k].exp_st);
        end

        // Line 5 in S; write 0x77 issues UPGR, snoop RDX before grant turns it into RDX.
        chk("upg_pre_state", line_st(1), S);
        cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 64'h77;
        @(posedge clk); #1;
        chk("upg_bus_req", bus_req, 1);
        chk("upg_cmd", bus_cmd, UPGR);
        chk("upg_addr", bus_addr, 5);
        snoop_valid = 1; snoop_cmd = RDX; snoop_addr = 5;
        #1;
        chk("upg_snoop_shared", snoop_shared, 1);
        chk("upg_snoop_flush", snoop_flush, 0);
        @(posedge clk); #1;
        snoop_valid = 0;
        chk("upg_cmd_rdx", bus_cmd, RDX);
        chk("upg_line_inval", line_st(1), I);
        chk("upg_req_held", bus_req, 1);
        bus_gnt = 1;
        @(posedge clk); #1;
        chk("upg_cmd_granted", bus_cmd, RDX);
        bus_done = 1; bus_rdata = 64'hDEAD; bus_shared = 0;
        @(posedge clk); #1;
        bus_done = 0; bus_gnt = 0;
        chk("upg_resp", cpu_resp, 1);
        chk("upg_rdata", cpu_rdata, 0);
        chk("upg_state", line_st(1), M);
        chk("upg_data", dut.lines[1].data, 64'h77);
        chk("upg_req_drop", bus_req, 0);
        cpu_req = 0;
        @(posedge clk); #1;
        chk("upg_resp_pulse", cpu_resp, 0);
        chk("upg_ready", cpu_ready, 1);

        // Read 9 evicts dirty 5 from the same index: WB first, then RD.
        run_cpu(0, 9, 0, 64'hBB, 0);
        chk("evict_ntx", ntx, 2);
        chk("evict_wb_cmd", tx_cmd[0], WB);
        chk("evict_wb_addr", tx_addr[0], 5);
        chk("evict_wb_data", tx_wdata[0], 64'h77);
        chk("evict_rd_cmd", tx_cmd[1], RD);
        chk("evict_rd_addr", tx_addr[1], 9);
        chk("evict_lat", lat - done_c, 1);
        chk("evict_rdata", rdata, 64'hBB);
        chk("evict_state", line_st(1), E);

        // Reset while a fill is outstanding.
        cpu_req = 1; cpu_we = 0; cpu_addr = 13;
        @(posedge clk); #1;
        chk("rstmid_bus_req", bus_req, 1);
        chk("rstmid_cmd", bus_cmd, RD);
        rst = 1; bus_gnt = 1;
        @(posedge clk); #1;
        chk("rstmid_req_drop", bus_req, 0);
        chk("rstmid_ready", cpu_ready, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("rstmid_line%0d_st", i), line_st(i), I);
        rst = 0; bus_gnt = 0; cpu_req = 0;
        @(posedge clk); #1;
        chk("rstmid_ready_after", cpu_ready, 1);
        chk("rstmid_req_idle", bus_req, 0);
        run_cpu(0, 9, 0, 64'hDD, 0);
        chk("rstmid_refetch_ntx", ntx, 1);
        chk("rstmid_refetch_rdata", rdata, 64'hDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
